// File: rtl/layer_sequencer.sv
// layer_sequencer: control sequencer for the inference pipeline.
// Walks IDLE -> RECV -> EMB -> (MIX, MIXW)* -> DENS -> COMP -> SEND and
// returns to IDLE with the done flag set. Loopback mode goes RECV -> SEND.
// The completed state (FIN) is encoded as IDLE with done=1.
//
// Optional feature: define SEQ_TIMEOUT_EN to build a per-stage watchdog.
// When it fires, the sequence ends early with timeout=1 and finish=1.
//
// Handshake: each X_run is high for the whole time the sequencer sits in
// stage X. The layer block answers with a single-cycle X_valid pulse. The
// sequencer acts on that pulse at the next clock edge. A pulse seen while
// X_run is low is dropped and is not remembered.
module layer_sequencer #(
    parameter int MIX_NUM        = 3,
    parameter int COMP_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       set,
    input  logic [1:0] mode,
    input  logic       recv_valid,
    input  logic       emb_valid,
    input  logic       mix_valid,
    input  logic       dense_valid,
    input  logic       send_valid,
    output logic       recv_run,
    output logic       emb_run,
    output logic       mix_run,
    output logic       dense_run,
    output logic       send_run,
    output logic [3:0] mix_idx,
    output logic       mix_first,
    output logic [2:0] state,
    output logic       finish,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RECV = 3'd1,
        S_EMB  = 3'd2,
        S_MIX  = 3'd3,
        S_MIXW = 3'd4,
        S_DENS = 3'd5,
        S_COMP = 3'd6,
        S_SEND = 3'd7
    } state_t;

    localparam logic [3:0] MIX_LAST  = 4'(MIX_NUM - 1);
    localparam logic [7:0] COMP_LAST = 8'(COMP_CYCLES - 1);

    state_t     state_q;
    logic       done_q;
    logic [3:0] mix_idx_q;
    logic [1:0] mode_q;
    logic [7:0] comp_cnt_q;

    logic       leave;      // current stage is complete this cycle
    logic       busy_int;
    logic       wdog_fire;  // watchdog expires this cycle

    assign busy_int = (state_q != S_IDLE) && !done_q;

    // Stage-complete decode, shared by the state machine and the watchdog
    always_comb begin
        leave = 1'b0;
        case (state_q)
            S_IDLE:  leave = !done_q && start;
            S_RECV:  leave = recv_valid;
            S_EMB:   leave = emb_valid;
            S_MIX:   leave = mix_valid;
            S_MIXW:  leave = 1'b1;
            S_DENS:  leave = dense_valid;
            S_COMP:  leave = (comp_cnt_q == COMP_LAST);
            S_SEND:  leave = send_valid;
            default: leave = 1'b0;
        endcase
    end

    // Sequencer state machine: set wins, then watchdog, then stage completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            mix_idx_q  <= 4'd0;
            mode_q     <= 2'd0;
            comp_cnt_q <= 8'd0;
        end else if (set) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            mix_idx_q  <= 4'd0;
            comp_cnt_q <= 8'd0;
        end else if (wdog_fire) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (leave) begin
                        state_q <= S_RECV;
                        mode_q  <= mode;
                    end
                end
                S_RECV: begin
                    // Reserved modes 2/3 run the full inference path
                    if (leave) state_q <= (mode_q == 2'd1) ? S_SEND : S_EMB;
                end
                S_EMB: begin
                    if (leave) begin
                        state_q   <= S_MIX;
                        mix_idx_q <= 4'd0;
                    end
                end
                S_MIX: begin
                    if (leave) begin
                        if (mix_idx_q == MIX_LAST) begin
                            state_q <= S_DENS;
                        end else begin
                            state_q   <= S_MIXW;
                            mix_idx_q <= mix_idx_q + 4'd1;
                        end
                    end
                end
                S_MIXW: begin
                    // One-cycle gap so mix_run drops and re-rises per pass
                    state_q <= S_MIX;
                end
                S_DENS: begin
                    if (leave) begin
                        state_q    <= S_COMP;
                        comp_cnt_q <= 8'd0;
                    end
                end
                S_COMP: begin
                    if (leave) state_q    <= S_SEND;
                    else       comp_cnt_q <= comp_cnt_q + 8'd1;
                end
                S_SEND: begin
                    if (leave) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [12:0] WDOG_LAST = 13'(TIMEOUT_CYCLES - 1);

    logic [12:0] wdog_q;
    logic        timeout_q;

    assign wdog_fire = busy_int && (wdog_q == WDOG_LAST);
    assign timeout   = timeout_q;

    // Per-stage watchdog: restarts on each stage change, counts while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= 13'd0;
            timeout_q <= 1'b0;
        end else if (set) begin
            wdog_q    <= 13'd0;
            timeout_q <= 1'b0;
        end else begin
            if (wdog_fire) timeout_q <= 1'b1;
            if (wdog_fire || leave || !busy_int) wdog_q <= 13'd0;
            else                                 wdog_q <= wdog_q + 13'd1;
        end
    end
`else
    // No watchdog: a stalled stage waits for set. The limit parameter is
    // kept so both builds accept the same instance parameters.
    localparam logic TIMEOUT_CFG_OK = (TIMEOUT_CYCLES > 0);

    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0 & TIMEOUT_CFG_OK;
`endif

    assign recv_run  = (state_q == S_RECV);
    assign emb_run   = (state_q == S_EMB);
    assign mix_run   = (state_q == S_MIX);
    assign dense_run = (state_q == S_DENS);
    assign send_run  = (state_q == S_SEND);

    assign mix_idx   = mix_idx_q;
    assign mix_first = (mix_idx_q == 4'd0);
    assign state     = state_q;
    assign finish    = done_q;
    assign busy      = busy_int;

endmodule
